// File: rtl/ibex_fp_pkg.sv
// Shared FP writeback types: accrued-flag layout, DesignWare status bit map and
// the buffered writeback entry.
package ibex_fp_pkg;

    localparam int unsigned DW_STATUS_W = 8;

    localparam int unsigned DW_ZERO     = 0;
    localparam int unsigned DW_INF      = 1;
    localparam int unsigned DW_INVALID  = 2;
    localparam int unsigned DW_TINY     = 3;
    localparam int unsigned DW_HUGE     = 4;
    localparam int unsigned DW_INEXACT  = 5;
    localparam int unsigned DW_HUGEINT  = 6;
    localparam int unsigned DW_DIVZ     = 7;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } fflags_t;

    typedef struct packed {
        logic                   is_int;
        logic [4:0]             addr;
        logic [31:0]            wdata;
        logic [DW_STATUS_W-1:0] status;
    } fpu_wb_entry_t;

    // Underflow is only reported when the tiny result was also inexact.
    function automatic fflags_t dw_status_to_fflags(input logic [DW_STATUS_W-1:0] s);
        fflags_t f;
        f.nv = s[DW_INVALID] | s[DW_HUGEINT];
        f.dz = s[DW_DIVZ];
        f.of = s[DW_HUGE];
        f.uf = s[DW_TINY] & s[DW_INEXACT];
        f.nx = s[DW_INEXACT];
        return f;
    endfunction

endpackage

// File: rtl/ibex_fpu_wb_buffer.sv
// FPU writeback buffer: in-order FIFO draining to the FP regfile port and the
// granted integer regfile port, accruing RISC-V fflags as entries retire.
module ibex_fpu_wb_buffer
    import ibex_fp_pkg::*;
#(
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned STATUS_W = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       fpu_valid_i,
    output logic                       fpu_ready_o,
    input  logic                       fpu_is_int_i,
    input  logic [4:0]                 fpu_addr_i,
    input  logic [31:0]                fpu_wdata_i,
    input  logic [STATUS_W-1:0]        fpu_status_i,
    output logic                       fp_we_o,
    output logic [4:0]                 fp_waddr_o,
    output logic [31:0]                fp_wdata_o,
    output logic                       int_req_o,
    input  logic                       int_gnt_i,
    output logic [4:0]                 int_waddr_o,
    output logic [31:0]                int_wdata_o,
    input  logic                       flush_i,
    input  logic                       csr_fflags_we_i,
    input  logic [4:0]                 csr_fflags_wdata_i,
    output logic [4:0]                 fflags_o,
    output logic                       pending_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    fpu_wb_entry_t       mem_q [DEPTH];
    logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]     count_q, count_d;
    logic [4:0]          fflags_q, fflags_d;

    fpu_wb_entry_t       head, push_entry;
    logic                empty, push, pop, pop_eff;
    logic [4:0]          flag_inc;

    assign empty       = (count_q == '0);
    assign head        = mem_q[rd_ptr_q];
    assign fpu_ready_o = (count_q < CntW'(DEPTH));

    assign push_entry.is_int = fpu_is_int_i;
    assign push_entry.addr   = fpu_addr_i;
    assign push_entry.wdata  = fpu_wdata_i;
    assign push_entry.status = fpu_status_i;

    // Address/data are gated by their strobes so idle ports read as zero.
    assign fp_we_o     = !empty && !head.is_int;
    assign int_req_o   = !empty &&  head.is_int;
    assign fp_waddr_o  = fp_we_o   ? head.addr  : '0;
    assign fp_wdata_o  = fp_we_o   ? head.wdata : '0;
    assign int_waddr_o = int_req_o ? head.addr  : '0;
    assign int_wdata_o = int_req_o ? head.wdata : '0;

    assign pending_o = !empty;
    assign count_o   = count_q;
    assign fflags_o  = fflags_q;

    always_comb begin
        push     = fpu_valid_i && fpu_ready_o && !flush_i;
        pop      = fp_we_o || (int_req_o && int_gnt_i);
        // Under flush only a granted integer write still retires.
        pop_eff  = flush_i ? (int_req_o && int_gnt_i) : pop;
        flag_inc = pop_eff ? 5'(dw_status_to_fflags(head.status)) : '0;

        fflags_d = csr_fflags_we_i ? (csr_fflags_wdata_i | flag_inc)
                                   : (fflags_q | flag_inc);

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            if (push && !pop)      count_d = count_q + CntW'(1);
            else if (!push && pop) count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            fflags_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            fflags_q <= fflags_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= push_entry;
    end

endmodule

// File: tb/tb_ibex_fpu_wb_buffer.sv
// Directed bench for ibex_fpu_wb_buffer with hand-computed expectations.
module tb_ibex_fpu_wb_buffer;

    localparam int unsigned DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fpu_valid, fpu_ready, fpu_is_int;
    logic [4:0]  fpu_addr;
    logic [31:0] fpu_wdata;
    logic [7:0]  fpu_status;
    logic        fp_we, int_req, int_gnt, flush, csr_we, pending;
    logic [4:0]  fp_waddr, int_waddr, csr_wdata, fflags;
    logic [31:0] fp_wdata, int_wdata;
    logic [1:0]  count;

    int n_checks = 0;
    int n_pass   = 0;

    ibex_fpu_wb_buffer #(.DEPTH(DEPTH), .STATUS_W(8)) dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .fpu_valid_i        (fpu_valid),
        .fpu_ready_o        (fpu_ready),
        .fpu_is_int_i       (fpu_is_int),
        .fpu_addr_i         (fpu_addr),
        .fpu_wdata_i        (fpu_wdata),
        .fpu_status_i       (fpu_status),
        .fp_we_o            (fp_we),
        .fp_waddr_o         (fp_waddr),
        .fp_wdata_o         (fp_wdata),
        .int_req_o          (int_req),
        .int_gnt_i          (int_gnt),
        .int_waddr_o        (int_waddr),
        .int_wdata_o        (int_wdata),
        .flush_i            (flush),
        .csr_fflags_we_i    (csr_we),
        .csr_fflags_wdata_i (csr_wdata),
        .fflags_o           (fflags),
        .pending_o          (pending),
        .count_o            (count)
    );

    always #5 clk = ~clk;

    // A stalled FPU result is only legal when the buffer is genuinely full.
    always @(posedge clk) begin
        if (rst_n && fpu_valid && !fpu_ready)
            assert (count == 2'(DEPTH)) else $error("valid held while not full");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic is_int, input logic [4:0] a,
                         input logic [31:0] d, input logic [7:0] s);
        fpu_valid  = v;
        fpu_is_int = is_int;
        fpu_addr   = a;
        fpu_wdata  = d;
        fpu_status = s;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 32'd0, 8'd0);
        int_gnt = 1'b0; flush = 1'b0; csr_we = 1'b0; csr_wdata = '0;
        #3;
        check("rst_count",  32'(count),     32'd0);
        check("rst_ready",  32'(fpu_ready), 32'd1);
        check("rst_fp_we",  32'(fp_we),     32'd0);
        check("rst_int_req",32'(int_req),   32'd0);
        check("rst_pending",32'(pending),   32'd0);
        check("rst_fflags", 32'(fflags),    32'd0);
        check("rst_waddr",  32'(fp_waddr),  32'd0);
        check("rst_wdata",  fp_wdata,       32'd0);
        check("rst_iwaddr", 32'(int_waddr), 32'd0);
        #4 rst_n = 1'b1;
        tick();

        // FP op: visible the cycle after the push edge, NX accrues on pop
        drive(1'b1, 1'b0, 5'd5, 32'h3F80_0000, 8'h20);
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 8'd0);
        check("fp_we",     32'(fp_we),    32'd1);
        check("fp_waddr",  32'(fp_waddr), 32'd5);
        check("fp_wdata",  fp_wdata,      32'h3F80_0000);
        check("fp_count1", 32'(count),    32'd1);
        check("fp_noflag", 32'(fflags),   32'd0);
        tick();
        check("fp_popped", 32'(fp_we),    32'd0);
        check("fp_fflags", 32'(fflags),   32'b00001);

        // Integer head blocks the FP entry until granted
        drive(1'b1, 1'b1, 5'd3, 32'h0000_00A5, 8'h28);
        tick();
        drive(1'b1, 1'b0, 5'd7, 32'h0000_0077, 8'h01);
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 8'd0);
        check("full_count", 32'(count),     32'd2);
        check("full_ready", 32'(fpu_ready), 32'd0);
        check("full_fp_we", 32'(fp_we),     32'd0);
        check("full_req",   32'(int_req),   32'd1);
        check("full_iaddr", 32'(int_waddr), 32'd3);
        check("full_idata", int_wdata,      32'h0000_00A5);
        tick();
        check("hold_req",   32'(int_req),   32'd1);
        check("hold_count", 32'(count),     32'd2);
        int_gnt = 1'b1;
        tick();
        int_gnt = 1'b0;
        check("after_gnt_req",  32'(int_req),  32'd0);
        check("after_gnt_fpwe", 32'(fp_we),    32'd1);
        check("after_gnt_addr", 32'(fp_waddr), 32'd7);
        check("after_gnt_cnt",  32'(count),    32'd1);
        tick();
        check("drain_pending", 32'(pending), 32'd0);
        check("int_fflags",    32'(fflags),  32'b00011);

        // Streaming push+pop across the pointer wrap
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b0, 5'(10 + i), 32'(256 + i), 8'h00);
            tick();
            check("strm_count", 32'(count),    32'd1);
            check("strm_addr",  32'(fp_waddr), 32'(10 + i));
            check("strm_data",  fp_wdata,      32'(256 + i));
        end
        drive(1'b0, 1'b0, 5'd0, 32'd0, 8'd0);
        tick();
        check("strm_empty", 32'(count), 32'd0);

        // CSR write colliding with a retiring DIVZ|HUGE op
        csr_we = 1'b1; csr_wdata = 5'b00000;
        tick();
        csr_we = 1'b0;
        check("csr_clear", 32'(fflags), 32'd0);
        drive(1'b1, 1'b0, 5'd1, 32'h1, 8'h90);
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 8'd0);
        csr_we = 1'b1; csr_wdata = 5'b10000;
        tick();
        csr_we = 1'b0;
        check("csr_collide", 32'(fflags), 32'b11100);

        // Flush without grant: entries and their flags discarded, push dropped
        drive(1'b1, 1'b1, 5'd4, 32'h4, 8'h20);
        csr_we = 1'b1; csr_wdata = 5'b00000;
        tick();
        csr_we = 1'b0;
        drive(1'b1, 1'b0, 5'd6, 32'h6, 8'h04);
        tick();
        check("fl_count2", 32'(count), 32'd2);
        drive(1'b1, 1'b0, 5'd9, 32'h9, 8'h20);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 32'd0, 8'd0);
        check("fl_pending", 32'(pending),   32'd0);
        check("fl_count",   32'(count),     32'd0);
        check("fl_fp_we",   32'(fp_we),     32'd0);
        check("fl_req",     32'(int_req),   32'd0);
        check("fl_fflags",  32'(fflags),    32'd0);
        check("fl_ready",   32'(fpu_ready), 32'd1);

        // Flush with grant: the integer write retires and its flags accrue
        drive(1'b1, 1'b1, 5'd8, 32'h8, 8'h20);
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 8'd0);
        flush = 1'b1; int_gnt = 1'b1;
        tick();
        flush = 1'b0; int_gnt = 1'b0;
        check("flg_count",  32'(count),  32'd0);
        check("flg_fflags", 32'(fflags), 32'b00001);

        // Asynchronous reset between edges with two entries buffered
        drive(1'b1, 1'b1, 5'd2, 32'h2, 8'h00);
        tick();
        drive(1'b1, 1'b0, 5'd3, 32'h3, 8'h00);
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 8'd0);
        check("ar_count2", 32'(count), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check("ar_fp_we",  32'(fp_we),     32'd0);
        check("ar_req",    32'(int_req),   32'd0);
        check("ar_count",  32'(count),     32'd0);
        check("ar_ready",  32'(fpu_ready), 32'd1);
        check("ar_fflags", 32'(fflags),    32'd0);
        tick();
        check("ar_hold",   32'(pending),   32'd0);
        rst_n = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
